interrupt_request_unit: RTL and testbench
=========================================

# interrupt_request_unit

Parametrised, clocked interrupt request register (IRR) for the PIC datapath, between the IR input pins and the priority resolver. Synchronises NUM_IR asynchronous request lines, detects rising edges or samples levels per channel, latches pending requests until acknowledged, freezes the IRR during INTA sequences without losing edges, and optionally flags overruns. It is the clocked, per-channel-mode generalisation of the existing 8-bit IRR logic.

## Interface
- NUM_IR, 8, number of interrupt request channels (1..32)
- SYNC_STAGES, 2, input synchroniser depth in flops (1..3)

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- Level_OR_Edge_trigger  in  NUM_IR  per-channel mode: 1 = level, 0 = edge
- Int_Req_Pins  in  NUM_IR  asynchronous IR lines
- Clear_bits_IRR  in  NUM_IR  one-cycle clear pulses from the INTA/ISR logic
- Freeze_IRR  in  1  holds IRR contents during an INTA sequence
- Clear_Overrun  in  1  clears all overrun flags
- Int_Req_Reg  out  NUM_IR  IRR contents
- Int_Pending  out  1  OR-reduction of Int_Req_Reg (combinational from the register)
- Overrun_Flags  out  NUM_IR  sticky per-channel overrun flags

## Operation
- Reset (reset_n=0 at clk edge): synchroniser flops, prev-sample reg, deferred-edge reg, mode-shadow reg, Int_Req_Reg, Overrun_Flags all 0; Int_Pending 0.
- s[i] = synchroniser output; prev[i] = s[i] from the previous cycle; edge[i] = s[i] & ~prev[i].
- Edge channel, not frozen: next IRR[i] = 1 if edge[i] or deferred[i]; else 0 if Clear_bits_IRR[i]; else hold. New edge coincident with clear leaves bit 1 (new request wins). Deferred[i] cleared once applied.
- Level channel, not frozen: next IRR[i] = 0 if Clear_bits_IRR[i], else s[i]. Bit re-asserts the following cycle if the line is still high.
- Freeze_IRR=1: IRR holds except that Clear_bits_IRR still clears. Edges seen during freeze set deferred[i] (edge channels only) and are applied on the first unfrozen cycle. Level channels resample on unfreeze.
- Mode change: when Level_OR_Edge_trigger[i] differs from its shadow copy, that cycle clears IRR[i], deferred[i] and Overrun_Flags[i] and loads the shadow. prev keeps tracking s, so a line already high does not create an edge.
- Overrun (edge channels): edge[i] while IRR[i]=1 and Clear_bits_IRR[i]=0, or edge while deferred[i]=1, sets Overrun_Flags[i]. Set beats simultaneous Clear_Overrun.
- Pins and prev reset to 0, so a line held high through reset yields one edge after reset release.

## Timing
- Pin high sampled at edge k: s rises at k+SYNC_STAGES-1, IRR bit visible after edge k+SYNC_STAGES (3 clocks for default 2 stages, counting the sampling edge).
- Clear pulse at edge c: IRR bit 0 after edge c; Int_Pending follows in the same cycle.
- Freeze release at edge f: deferred edges appear in IRR after edge f+1.
- Clear_Overrun: flags 0 after the edge at which it is sampled.
- No combinational path from any input to any output.

## Configuration
- IRR_OVERRUN_EN defined: overrun detection and Overrun_Flags / Clear_Overrun behaviour as above.
- Not defined: overrun logic not built; Overrun_Flags tied to 0; Clear_Overrun ignored; all other behaviour identical.

## Test plan
- Reset with IR3 held high, all channels edge, release reset -> Int_Req_Reg=8'h08 three clocks later, Int_Pending=1; pulse Clear_bits_IRR=8'h08 -> 8'h00 next cycle, no re-set while line stays high.
- IR5 level mode, line high 10 cycles then low -> bit 5 follows with 2-cycle lag; clear pulse mid-high -> bit 0 for one cycle, then 1 again.
- Freeze_IRR=1, IR1 rising edge (edge mode), hold freeze 5 cycles -> IRR unchanged; release -> bit 1 set one cycle after release.
- IR0 edge, clear pulse coincident with a new internal edge -> bit 0 stays 1, no overrun flag.
- IRR_OVERRUN_EN: IR2 latched, toggle IR2 low/high without clear -> Overrun_Flags=8'h04; Clear_Overrun with no new edge -> 8'h00. Without macro -> flags stay 8'h00.
- NUM_IR=16, SYNC_STAGES=3: toggle channel 12 mode from edge to level while IRR[12]=1 -> bit cleared that cycle, line high -> bit returns in level mode next cycle.

Source files
------------

// File: rtl/interrupt_request_unit.sv
// Interrupt request register: synchronises IR lines, edge/level capture, freeze with deferred edges.
// Optional overrun detection is built when IRR_OVERRUN_EN is defined.
module interrupt_request_unit #(
   parameter int NUM_IR      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_IR-1:0] Level_OR_Edge_trigger,
   input  logic [NUM_IR-1:0] Int_Req_Pins,
   input  logic [NUM_IR-1:0] Clear_bits_IRR,
   input  logic              Freeze_IRR,
   input  logic              Clear_Overrun,
   output logic [NUM_IR-1:0] Int_Req_Reg,
   output logic              Int_Pending,
   output logic [NUM_IR-1:0] Overrun_Flags
);

   logic [NUM_IR-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IR-1:0] prev_q;
   logic [NUM_IR-1:0] mode_q;
   logic [NUM_IR-1:0] irr_q, irr_d;
   logic [NUM_IR-1:0] def_q, def_d;
   logic [NUM_IR-1:0] ovr_q, ovr_d;
   logic [NUM_IR-1:0] s_w, rise_w, mode_chg_w;

   assign s_w        = sync_q[SYNC_STAGES-1];
   assign rise_w     = s_w & ~prev_q;
   assign mode_chg_w = Level_OR_Edge_trigger ^ mode_q;

   // Per-channel next state; a mode change wipes the channel for one cycle.
   always_comb begin
      irr_d = irr_q;
      def_d = def_q;
      for (int i = 0; i < NUM_IR; i++) begin
         if (mode_chg_w[i]) begin
            irr_d[i] = 1'b0;
            def_d[i] = 1'b0;
         end else if (Level_OR_Edge_trigger[i]) begin
            def_d[i] = 1'b0;
            if (Clear_bits_IRR[i])
               irr_d[i] = 1'b0;
            else if (!Freeze_IRR)
               irr_d[i] = s_w[i];
         end else if (Freeze_IRR) begin
            if (Clear_bits_IRR[i])
               irr_d[i] = 1'b0;
            if (rise_w[i])
               def_d[i] = 1'b1;
         end else begin
            // A new edge (live or deferred) beats a coincident clear.
            if (rise_w[i] || def_q[i])
               irr_d[i] = 1'b1;
            else if (Clear_bits_IRR[i])
               irr_d[i] = 1'b0;
            def_d[i] = 1'b0;
         end
      end
   end

`ifdef IRR_OVERRUN_EN
   always_comb begin
      ovr_d = ovr_q;
      for (int i = 0; i < NUM_IR; i++) begin
         if (mode_chg_w[i])
            ovr_d[i] = 1'b0;
         else if (!Level_OR_Edge_trigger[i] && rise_w[i] &&
                  ((irr_q[i] && !Clear_bits_IRR[i]) || def_q[i]))
            ovr_d[i] = 1'b1;
         else if (Clear_Overrun)
            ovr_d[i] = 1'b0;
      end
   end
`else
   logic unused_clear_overrun;
   assign unused_clear_overrun = Clear_Overrun;
   assign ovr_d = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < SYNC_STAGES; k++)
            sync_q[k] <= '0;
         prev_q <= '0;
         mode_q <= '0;
         irr_q  <= '0;
         def_q  <= '0;
         ovr_q  <= '0;
      end else begin
         sync_q[0] <= Int_Req_Pins;
         for (int k = 1; k < SYNC_STAGES; k++)
            sync_q[k] <= sync_q[k-1];
         prev_q <= s_w;
         mode_q <= Level_OR_Edge_trigger;
         irr_q  <= irr_d;
         def_q  <= def_d;
         ovr_q  <= ovr_d;
      end
   end

   assign Int_Req_Reg   = irr_q;
   assign Int_Pending   = |irr_q;
   assign Overrun_Flags = ovr_q;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Scoreboarded bench for interrupt_request_unit: directed scenarios followed by random traffic.
module tb_interrupt_request_unit;

   localparam int N = 8;
   localparam int S = 2;
   localparam int W = 2*N + 1;
`ifdef IRR_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n;
   logic [N-1:0] lvl_i, pins_i, clr_i;
   logic         frz_i, clro_i;
   logic [N-1:0] irr_o, ovr_o;
   logic         pend_o;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];

   // Reference model state: sample history (index 0 = newest) plus per-channel flags.
   logic [N-1:0] m_samp[$];
   logic [N-1:0] m_prev, m_irr, m_def, m_ovr, m_mode;

   // Driven values for the next clock.
   logic         d_rst, d_frz, d_clro;
   logic [N-1:0] d_pins, d_lvl, d_clr;

   always #5 clk = ~clk;

   interrupt_request_unit #(.NUM_IR(N), .SYNC_STAGES(S)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .Level_OR_Edge_trigger(lvl_i),
      .Int_Req_Pins         (pins_i),
      .Clear_bits_IRR       (clr_i),
      .Freeze_IRR           (frz_i),
      .Clear_Overrun        (clro_i),
      .Int_Req_Reg          (irr_o),
      .Int_Pending          (pend_o),
      .Overrun_Flags        (ovr_o)
   );

   task automatic model_step();
      logic [N-1:0] s, rise, n_irr, n_def, n_ovr;
      if (!d_rst) begin
         m_samp.delete();
         for (int k = 0; k < S; k++) m_samp.push_back('0);
         m_prev = '0; m_irr = '0; m_def = '0; m_ovr = '0; m_mode = '0;
      end else begin
         s = m_samp[S-1];
         rise = s & ~m_prev;
         n_irr = m_irr; n_def = m_def; n_ovr = m_ovr;
         for (int i = 0; i < N; i++) begin
            if (d_lvl[i] != m_mode[i]) begin
               n_irr[i] = 1'b0; n_def[i] = 1'b0; n_ovr[i] = 1'b0;
            end else begin
               if (OVR_EN && !d_lvl[i] && rise[i] && ((m_irr[i] && !d_clr[i]) || m_def[i]))
                  n_ovr[i] = 1'b1;
               else if (OVR_EN && d_clro)
                  n_ovr[i] = 1'b0;
               if (d_lvl[i]) begin
                  n_def[i] = 1'b0;
                  n_irr[i] = d_clr[i] ? 1'b0 : (d_frz ? m_irr[i] : s[i]);
               end else if (d_frz) begin
                  n_irr[i] = m_irr[i] & ~d_clr[i];
                  n_def[i] = m_def[i] | rise[i];
               end else begin
                  n_irr[i] = rise[i] | m_def[i] | (m_irr[i] & ~d_clr[i]);
                  n_def[i] = 1'b0;
               end
            end
         end
         m_mode = d_lvl;
         m_samp.push_front(d_pins);
         void'(m_samp.pop_back());
         m_prev = s;
         m_irr = n_irr; m_def = n_def; m_ovr = n_ovr;
      end
      exp_q.push_back({m_irr, |m_irr, m_ovr});
   endtask

   // One clock: apply inputs at the falling edge, predict the result of the next rising edge.
   task automatic tick();
      @(negedge clk);
      reset_n = d_rst; pins_i = d_pins; lvl_i = d_lvl;
      clr_i = d_clr; frz_i = d_frz; clro_i = d_clro;
      model_step();
      d_clr = '0;
      d_clro = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rising edge yields one registered output set to compare.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("irr", 32'(irr_o), 32'(e[W-1 -: N]));
            check("pending", 32'(pend_o), 32'(e[N]));
            check("overrun", 32'(ovr_o), 32'(e[N-1:0]));
         end
      end
   end

   initial begin
      d_rst = 1'b0; d_pins = 8'h08; d_lvl = '0; d_clr = '0; d_frz = 1'b0; d_clro = 1'b0;
      ticks(2);

      // IR3 held high through reset produces one edge after release.
      d_rst = 1'b1;
      ticks(4);
      check("ir3_after_reset", 32'(irr_o), 32'h08);
      check("pending_after_reset", 32'(pend_o), 32'h1);
      d_clr = 8'h08;
      ticks(2);
      check("ir3_cleared", 32'(irr_o), 32'h00);
      ticks(3);
      check("ir3_no_reset", 32'(irr_o), 32'h00);

      // IR5 level mode with a mid-high clear pulse.
      d_lvl = 8'h20;
      tick();
      d_pins = 8'h28;
      ticks(4);
      check("ir5_level_set", 32'(irr_o[5]), 32'h1);
      d_clr = 8'h20;
      ticks(2);
      check("ir5_level_cleared", 32'(irr_o[5]), 32'h0);
      tick();
      check("ir5_level_reasserted", 32'(irr_o[5]), 32'h1);
      ticks(3);
      d_pins = 8'h08;
      ticks(4);
      check("ir5_level_dropped", 32'(irr_o[5]), 32'h0);

      // IR1 edge during freeze is deferred until release.
      d_frz = 1'b1;
      tick();
      d_pins = d_pins | 8'h02;
      ticks(6);
      check("ir1_frozen", 32'(irr_o[1]), 32'h0);
      d_frz = 1'b0;
      tick();
      check("ir1_release_edge", 32'(irr_o[1]), 32'h0);
      tick();
      check("ir1_applied", 32'(irr_o[1]), 32'h1);

      // IR0 new edge coincident with its clear pulse keeps the bit.
      d_pins = d_pins | 8'h01;
      ticks(4);
      d_pins = d_pins & ~8'h01;
      ticks(3);
      d_pins = d_pins | 8'h01;
      ticks(2);
      d_clr = 8'h01;
      ticks(2);
      check("ir0_edge_beats_clear", 32'(irr_o[0]), 32'h1);
      check("ir0_no_overrun", 32'(ovr_o[0]), 32'h0);

      // IR2 re-edge while latched flags an overrun when built in.
      d_pins = d_pins | 8'h04;
      ticks(4);
      d_pins = d_pins & ~8'h04;
      ticks(2);
      d_pins = d_pins | 8'h04;
      ticks(4);
      check("ir2_overrun", 32'(ovr_o), OVR_EN ? 32'h04 : 32'h00);
      d_clro = 1'b1;
      ticks(2);
      check("overrun_cleared", 32'(ovr_o), 32'h00);

      // IR2 switches edge->level while latched and high.
      d_lvl = d_lvl | 8'h04;
      ticks(2);
      check("ir2_mode_change_clear", 32'(irr_o[2]), 32'h0);
      tick();
      check("ir2_level_return", 32'(irr_o[2]), 32'h1);

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         d_rst = ($urandom_range(0, 299) != 0);
         d_pins = d_pins ^ N'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 3) == 0) d_clr = N'($urandom & $urandom);
         if ($urandom_range(0, 15) == 0) d_frz = ~d_frz;
         if ($urandom_range(0, 39) == 0) d_lvl[$urandom_range(0, N-1)] ^= 1'b1;
         d_clro = ($urandom_range(0, 9) == 0);
         tick();
      end
      d_rst = 1'b1;
      ticks(2);
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
